// File: rtl/dec_code_pkg.sv
// Shared constants and types for the 32-bit DEC-TED codeword.
// Codeword layout: {parity, data[31:0], check[11:0]}.
package dec_code_pkg;

  localparam int K = 32;
  localparam int R = 12;
  localparam int N = 45;

  localparam logic [R-1:0] G_LOW = 12'h539;

  localparam int CHK_LSB = 0;
  localparam int CHK_MSB = R - 1;
  localparam int DAT_LSB = R;
  localparam int DAT_MSB = R + K - 1;
  localparam int PAR_BIT = N - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/dec_lfsr_step.sv
// Combinational BCH division step: folds BPC data bits, MSB first,
// into the 12-bit remainder and the running data parity.
module dec_lfsr_step
  import dec_code_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic [R-1:0]   r_i,
  input  logic [BPC-1:0] d_i,
  input  logic           p_i,
  output logic [R-1:0]   r_o,
  output logic           p_o
);

  logic [R-1:0] rr;
  logic         pp;
  logic         fb;

  always_comb begin
    rr = r_i;
    pp = p_i;
    fb = 1'b0;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb = d_i[i] ^ rr[R-1];
      rr = {rr[R-2:0], 1'b0} ^ (fb ? G_LOW : '0);
      pp = pp ^ d_i[i];
    end
    r_o = rr;
    p_o = pp;
  end

endmodule

// File: rtl/dec_ted_encoder.sv
// Sequential DEC-TED encoder: BCH(63,51) shortened to 32 data bits,
// 12 check bits from a multi-bit LFSR plus an overall even parity bit.
module dec_ted_encoder
  import dec_code_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_code,
  output logic         busy
);

  localparam int          CYC  = K / BPC;
  localparam logic [5:0]  LAST = 6'(CYC - 1);

  state_e       state_q, state_d;
  logic [K-1:0] sh_q, sh_d;
  logic [K-1:0] dat_q, dat_d;
  logic [R-1:0] r_q, r_d;
  logic         p_q, p_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [N-1:0] code_q, code_d;

  logic [R-1:0] r_nx;
  logic         p_nx;

  dec_lfsr_step #(
    .BPC(BPC)
  ) u_step (
    .r_i(r_q),
    .d_i(sh_q[K-1 -: BPC]),
    .p_i(p_q),
    .r_o(r_nx),
    .p_o(p_nx)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dat_d   = dat_q;
    r_d     = r_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          dat_d   = in_data;
          r_d     = '0;
          p_d     = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        r_d  = r_nx;
        p_d  = p_nx;
        sh_d = sh_q << BPC;
        if (cnt_q == LAST) begin
          // Parity so far covers data only; fold in the final check bits.
          code_d  = {p_nx ^ (^r_nx), dat_q, r_nx};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      dat_q   <= '0;
      r_q     <= '0;
      p_q     <= 1'b0;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      r_q     <= r_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign out_code  = code_q;
  assign busy      = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_dec_ted_encoder.sv
// Directed and random checks of dec_ted_encoder at BPC = 1, 2, 4, 8
// against a polynomial long-division reference.
module tb_dec_ted_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [31:0] din;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  bz;
  logic [44:0] oc [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    dec_ted_encoder #(
      .BPC(1 << g)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(iv[g]),
      .in_ready(ir[g]),
      .in_data(din),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_code(oc[g]),
      .busy(bz[g])
    );
  end

  function automatic logic [11:0] rem44(input logic [43:0] c);
    logic [43:0] v;
    v = c;
    for (int i = 43; i >= 12; i--)
      if (v[i]) v = v ^ (44'h1539 << (i - 12));
    return v[11:0];
  endfunction

  function automatic logic [44:0] model(input logic [31:0] d);
    logic [11:0] chk;
    chk = rem44({d, 12'h000});
    return {^{d, chk}, d, chk};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input int idx, output logic [44:0] code,
                          output int lat);
    @(negedge clk);
    iv[idx] = 1'b0;
    lat = 1;
    while (!ov[idx] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    code = oc[idx];
    ordy[idx] = 1'b1;
    @(negedge clk);
    ordy[idx] = 1'b0;
    chk("post_xfer_ov", 64'(ov[idx]), 64'd0);
    chk("post_xfer_ready", 64'(ir[idx]), 64'd1);
  endtask

  task automatic run(input int idx, input logic [31:0] d,
                     output logic [44:0] code, output int lat);
    int n;
    @(negedge clk);
    din = d;
    iv[idx] = 1'b1;
    n = 0;
    while (!ir[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 200), 64'd1);
    wait_out(idx, code, lat);
  endtask

  logic [44:0] c, ca, cb, cab, c0;
  logic [31:0] a, b, rd;
  int          lat;
  bit          seen;

  initial begin
    rst  = 1'b1;
    iv   = 4'b0001;
    ordy = 4'b0000;
    din  = 32'h0000_0001;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(ir[0]), 64'd0);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_out_code", 64'(oc[0]), 64'd0);
    chk("rst_busy", 64'(bz[0]), 64'd0);
    rst = 1'b0;
    #1;
    chk("first_ready", 64'(ir[0]), 64'd1);
    wait_out(0, c, lat);
    chk("one_lat_bpc1", 64'(lat), 64'd33);
    chk("one_code_bpc1", 64'(c), 64'h1000_0000_1539);

    run(0, 32'h0000_0000, c, lat);
    chk("zero_code", 64'(c), 64'd0);
    run(0, 32'hFFFF_FFFF, c, lat);
    chk("ones_code", 64'(c), 64'(model(32'hFFFF_FFFF)));
    chk("ones_parity", 64'(^c), 64'd0);

    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    run(0, a, ca, lat);
    run(0, b, cb, lat);
    run(0, a ^ b, cab, lat);
    chk("lin_a", 64'(ca), 64'(model(a)));
    chk("lin_b", 64'(cb), 64'(model(b)));
    chk("linearity", 64'(ca ^ cb), 64'(cab));

    // Backpressure with a stray in_valid pulse during SHIFT.
    @(negedge clk);
    din = 32'hCAFE_F00D;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (5) @(negedge clk);
    din = 32'h0BAD_BEEF;
    iv[0] = 1'b1;
    chk("shift_ready", 64'(ir[0]), 64'd0);
    chk("shift_busy", 64'(bz[0]), 64'd1);
    @(negedge clk);
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    c0 = oc[0];
    chk("bp_code", 64'(c0), 64'(model(32'hCAFE_F00D)));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", 64'(oc[0]), 64'(c0));
      chk("bp_valid", 64'(ov[0]), 64'd1);
      chk("bp_ready", 64'(ir[0]), 64'd0);
      chk("bp_busy", 64'(bz[0]), 64'd1);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp_rel_valid", 64'(ov[0]), 64'd0);
    chk("bp_rel_ready", 64'(ir[0]), 64'd1);
    chk("bp_rel_busy", 64'(bz[0]), 64'd0);

    // Reset at SHIFT cycle 15 discards the word.
    @(negedge clk);
    din = 32'h55AA_55AA;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", 64'(ir[0]), 64'd0);
    chk("abort_rst_valid", 64'(ov[0]), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    ordy[0] = 1'b0;
    chk("abort_no_out", 64'(seen), 64'd0);
    chk("abort_idle", 64'(bz[0]), 64'd0);
    run(0, 32'h1357_9BDF, c, lat);
    chk("fresh_code", 64'(c), 64'(model(32'h1357_9BDF)));
    chk("fresh_lat", 64'(lat), 64'd33);

    for (int k = 1; k < 4; k++) begin
      run(k, 32'h0000_0001, c, lat);
      chk("one_code_bpcN", 64'(c), 64'h1000_0000_1539);
      chk("one_lat_bpcN", 64'(lat), 64'(32 / (1 << k) + 1));
      for (int j = 0; j < 1000; j++) begin
        rd = $urandom;
        run(k, rd, c, lat);
        chk("rand_code", 64'(c), 64'(model(rd)));
        chk("rand_lat", 64'(lat), 64'(32 / (1 << k) + 1));
        chk("rand_parity", 64'(^c), 64'd0);
        chk("rand_syndrome", 64'(rem44(c[43:0])), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
